// File: rtl/fwd_sb.sv
// Decode-stage operand forwarding, hazard interlock and long-latency busy scoreboard.
// Also keeps a saturating stall-cycle counter and a sticky consecutive-stall watchdog.
module fwd_sb #(
  parameter int XLEN    = 32,
  parameter int NUM_RD  = 2,
  parameter int NUM_STG = 3,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    flush_i,
  input  logic [5*NUM_RD-1:0]     D_rs_i,
  input  logic [XLEN*NUM_RD-1:0]  D_rs_data_i,
  input  logic                    D_need_rd_i,
  input  logic [4:0]              D_rd_i,
  input  logic [NUM_STG-1:0]      stg_vld_i,
  input  logic [5*NUM_STG-1:0]    stg_rd_i,
  input  logic [NUM_STG-1:0]      stg_rdy_i,
  input  logic [XLEN*NUM_STG-1:0] stg_data_i,
  input  logic                    mc_issue_i,
  input  logic [4:0]              mc_rd_i,
  input  logic                    mc_done_i,
  input  logic [4:0]              mc_done_rd_i,
  input  logic [XLEN-1:0]         mc_done_data_i,
  output logic [XLEN*NUM_RD-1:0]  D_fwd_o,
  output logic                    stall_o,
  output logic [31:0]             busy_o,
  output logic [CNT_W-1:0]        perf_stall_o,
  output logic                    wdog_o
);

  typedef struct packed {
    logic            haz;
    logic [XLEN-1:0] data;
  } fwd_res_t;

  logic [31:0]       busy_q, busy_d;
  logic [CNT_W-1:0]  perf_q;
  logic [15:0]       consec_q;
  logic              wdog_q;
  logic [NUM_RD-1:0] port_haz;
  logic              waw_haz;

  // Resolve one source register: x0, then youngest matching stage, then
  // same-cycle mc write-back, then scoreboard, then the register file.
  function automatic fwd_res_t resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf_data);
    fwd_res_t res;
    logic     found;
    res.haz  = 1'b0;
    res.data = rf_data;
    found    = 1'b0;
    if (rs == 5'd0) begin
      res.data = '0;
    end else begin
      for (int k = 0; k < NUM_STG; k++) begin
        if (!found && stg_vld_i[k] && (stg_rd_i[5*k +: 5] == rs)) begin
          found = 1'b1;
          if (stg_rdy_i[k]) res.data = stg_data_i[XLEN*k +: XLEN];
          else              res.haz  = 1'b1;
        end
      end
      if (!found) begin
        if (mc_done_i && (mc_done_rd_i == rs)) res.data = mc_done_data_i;
        else if (busy_q[rs])                   res.haz  = 1'b1;
      end
    end
    return res;
  endfunction

  // NOTE: every signal written in an always_comb gets a default at the top so no
  // path leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    fwd_res_t res;
    res      = '0;
    port_haz = '0;
    D_fwd_o  = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      res = resolve(D_rs_i[5*r +: 5], D_rs_data_i[XLEN*r +: XLEN]);
      port_haz[r]               = res.haz;
      D_fwd_o[XLEN*r +: XLEN]   = res.data;
    end
  end

  // A write-back landing this cycle retires the pending write, so no WAW stall.
  assign waw_haz = D_need_rd_i && (D_rd_i != 5'd0) && busy_q[D_rd_i] &&
                   !(mc_done_i && (mc_done_rd_i == D_rd_i));
  assign stall_o = (|port_haz) | waw_haz;

  // Done clears before issue sets, so a same-rd collision leaves the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (mc_done_i)  busy_d[mc_done_rd_i] = 1'b0;
      if (mc_issue_i) busy_d[mc_rd_i]      = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q   <= '0;
      perf_q   <= '0;
      consec_q <= '0;
      wdog_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (stall_o && !flush_i && (perf_q != '1)) perf_q <= perf_q + CNT_W'(1);
      if (!stall_o || flush_i) begin
        consec_q <= '0;
      end else if (consec_q != '1) begin
        consec_q <= consec_q + 16'd1;
        if ((consec_q + 16'd1) == 16'(TIMEOUT)) wdog_q <= 1'b1;
      end
    end
  end

  assign busy_o       = busy_q;
  assign perf_stall_o = perf_q;
  assign wdog_o       = wdog_q;

endmodule

// File: tb/tb_fwd_sb.sv
// Testbench for fwd_sb: directed scenarios plus randomized traffic checked
// against a rule-level reference model of forwarding, scoreboard and counters.
module tb_fwd_sb;

  localparam int XLEN    = 32;
  localparam int NUM_RD  = 2;
  localparam int NUM_STG = 3;
  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 8;
  localparam int PMAX    = (1 << CNT_W) - 1;

  logic                    clk_i = 1'b0;
  logic                    rst_n_i;
  logic                    flush_i;
  logic [5*NUM_RD-1:0]     D_rs_i;
  logic [XLEN*NUM_RD-1:0]  D_rs_data_i;
  logic                    D_need_rd_i;
  logic [4:0]              D_rd_i;
  logic [NUM_STG-1:0]      stg_vld_i;
  logic [5*NUM_STG-1:0]    stg_rd_i;
  logic [NUM_STG-1:0]      stg_rdy_i;
  logic [XLEN*NUM_STG-1:0] stg_data_i;
  logic                    mc_issue_i;
  logic [4:0]              mc_rd_i;
  logic                    mc_done_i;
  logic [4:0]              mc_done_rd_i;
  logic [XLEN-1:0]         mc_done_data_i;
  logic [XLEN*NUM_RD-1:0]  D_fwd_o;
  logic                    stall_o;
  logic [31:0]             busy_o;
  logic [CNT_W-1:0]        perf_stall_o;
  logic                    wdog_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [31:0] m_busy;
  int        m_perf;
  int        m_consec;
  bit        m_wdog;

  fwd_sb #(.XLEN(XLEN), .NUM_RD(NUM_RD), .NUM_STG(NUM_STG), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .D_rs_i(D_rs_i), .D_rs_data_i(D_rs_data_i), .D_need_rd_i(D_need_rd_i), .D_rd_i(D_rd_i),
    .stg_vld_i(stg_vld_i), .stg_rd_i(stg_rd_i), .stg_rdy_i(stg_rdy_i), .stg_data_i(stg_data_i),
    .mc_issue_i(mc_issue_i), .mc_rd_i(mc_rd_i), .mc_done_i(mc_done_i),
    .mc_done_rd_i(mc_done_rd_i), .mc_done_data_i(mc_done_data_i),
    .D_fwd_o(D_fwd_o), .stall_o(stall_o), .busy_o(busy_o),
    .perf_stall_o(perf_stall_o), .wdog_o(wdog_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [XLEN-1:0] fwd_of(input int r);
    return D_fwd_o[XLEN*r +: XLEN];
  endfunction

  // Expected combinational outputs from the forwarding rules.
  function automatic void exp_comb(output bit stall, output logic [XLEN*NUM_RD-1:0] fwd);
    stall = 1'b0;
    fwd   = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      int unsigned rs;
      bit          decided;
      logic [XLEN-1:0] val;
      rs      = D_rs_i[5*r +: 5];
      val     = D_rs_data_i[XLEN*r +: XLEN];
      decided = 1'b0;
      if (rs == 0) begin
        val = '0;
        decided = 1'b1;
      end
      for (int k = 0; k < NUM_STG; k++) begin
        if (!decided && stg_vld_i[k] && stg_rd_i[5*k +: 5] == rs) begin
          decided = 1'b1;
          if (stg_rdy_i[k]) val = stg_data_i[XLEN*k +: XLEN];
          else              stall = 1'b1;
        end
      end
      if (!decided) begin
        if (mc_done_i && mc_done_rd_i == rs) val = mc_done_data_i;
        else if (m_busy[rs])                 stall = 1'b1;
      end
      fwd[XLEN*r +: XLEN] = val;
    end
    if (D_need_rd_i && D_rd_i != 0 && m_busy[D_rd_i] && !(mc_done_i && mc_done_rd_i == D_rd_i))
      stall = 1'b1;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_perf = 0; m_consec = 0; m_wdog = 1'b0;
  endtask

  // One clock cycle: compare combinational outputs, advance model, compare state.
  task automatic cycle();
    bit s;
    logic [XLEN*NUM_RD-1:0] f;
    #1;
    exp_comb(s, f);
    checks++;
    if (stall_o !== s) begin
      errors++;
      $display("FAIL stall t=%0t got %0b exp %0b", $time, stall_o, s);
    end
    if (!s) begin
      for (int r = 0; r < NUM_RD; r++) begin
        checks++;
        if (fwd_of(r) !== f[XLEN*r +: XLEN]) begin
          errors++;
          $display("FAIL fwd%0d t=%0t got %h exp %h", r, $time, fwd_of(r), f[XLEN*r +: XLEN]);
        end
      end
    end
    if (flush_i) begin
      m_busy = '0;
    end else begin
      if (mc_done_i  && mc_done_rd_i != 0) m_busy[mc_done_rd_i] = 1'b0;
      if (mc_issue_i && mc_rd_i != 0)      m_busy[mc_rd_i]      = 1'b1;
    end
    if (s && !flush_i && m_perf < PMAX) m_perf++;
    if (!s || flush_i) m_consec = 0;
    else begin
      m_consec++;
      if (m_consec == TIMEOUT) m_wdog = 1'b1;
    end
    @(negedge clk_i);
    checks++;
    if (busy_o !== m_busy) begin
      errors++;
      $display("FAIL busy t=%0t got %h exp %h", $time, busy_o, m_busy);
    end
    checks++;
    if (perf_stall_o !== CNT_W'(m_perf)) begin
      errors++;
      $display("FAIL perf t=%0t got %0d exp %0d", $time, perf_stall_o, m_perf);
    end
    checks++;
    if (wdog_o !== m_wdog) begin
      errors++;
      $display("FAIL wdog t=%0t got %0b exp %0b", $time, wdog_o, m_wdog);
    end
  endtask

  task automatic clear_inputs();
    flush_i = 0; D_rs_i = '0; D_rs_data_i = '0; D_need_rd_i = 0; D_rd_i = '0;
    stg_vld_i = '0; stg_rd_i = '0; stg_rdy_i = '0; stg_data_i = '0;
    mc_issue_i = 0; mc_rd_i = '0; mc_done_i = 0; mc_done_rd_i = '0; mc_done_data_i = '0;
  endtask

  task automatic set_stg(input int k, input bit vld, input int rd, input bit rdy, input logic [XLEN-1:0] data);
    stg_vld_i[k] = vld; stg_rd_i[5*k +: 5] = 5'(rd); stg_rdy_i[k] = rdy; stg_data_i[XLEN*k +: XLEN] = data;
  endtask

  task automatic set_rs(input int r, input int rs, input logic [XLEN-1:0] data);
    D_rs_i[5*r +: 5] = 5'(rs); D_rs_data_i[XLEN*r +: XLEN] = data;
  endtask

  task automatic apply_reset();
    rst_n_i = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    clear_inputs();
    set_rs(0, 9, 32'h1234_5678);
    model_reset();
    #12;
    checks++;
    if (busy_o !== 32'h0 || perf_stall_o !== '0 || wdog_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%h perf=%0d wdog=%0b stall=%0b exp 0", busy_o, perf_stall_o, wdog_o, stall_o);
    end
    checks++;
    if (fwd_of(0) !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset_rf_pass got %h exp 12345678", fwd_of(0));
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    clear_inputs();
    cycle();
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    set_rs(0, 5, 32'hDEAD_0001);
    set_rs(1, 0, 32'hDEAD_0002);
    set_stg(0, 1, 5, 1, 32'hA);
    set_stg(2, 1, 5, 1, 32'hB);
    #1;
    checks++;
    if (fwd_of(0) !== 32'hA || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL youngest_wins got %h stall %0b exp 0000000a stall 0", fwd_of(0), stall_o);
    end
    checks++;
    if (fwd_of(1) !== 32'h0) begin
      errors++;
      $display("FAIL x0_zero got %h exp 00000000", fwd_of(1));
    end
    cycle();
    stg_vld_i[0] = 1'b0;
    #1;
    checks++;
    if (fwd_of(0) !== 32'hB) begin
      errors++;
      $display("FAIL oldest_stage got %h exp 0000000b", fwd_of(0));
    end
    cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_rs(1, 7, 32'h7777);
    set_stg(0, 1, 7, 0, 32'h0);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall got %0b exp 1", stall_o);
    end
    cycle();
    set_stg(0, 0, 0, 0, 32'h0);
    set_stg(1, 1, 7, 1, 32'h33);
    #1;
    checks++;
    if (fwd_of(1) !== 32'h33 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL load_use_fwd got %h stall %0b exp 00000033 stall 0", fwd_of(1), stall_o);
    end
    cycle();
  endtask

  task automatic test_mc();
    apply_reset();
    mc_issue_i = 1; mc_rd_i = 5'd9;
    cycle();
    mc_issue_i = 0;
    set_rs(0, 9, 32'h9999);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (stall_o !== 1'b1) begin
        errors++;
        $display("FAIL mc_busy_stall cycle %0d got %0b exp 1", i, stall_o);
      end
      cycle();
    end
    checks++;
    if (perf_stall_o !== CNT_W'(4)) begin
      errors++;
      $display("FAIL perf_four got %0d exp 4", perf_stall_o);
    end
    mc_done_i = 1; mc_done_rd_i = 5'd9; mc_done_data_i = 32'h55;
    #1;
    checks++;
    if (fwd_of(0) !== 32'h55 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL mc_bypass got %h stall %0b exp 00000055 stall 0", fwd_of(0), stall_o);
    end
    cycle();
    checks++;
    if (busy_o[9] !== 1'b0) begin
      errors++;
      $display("FAIL mc_clear got %0b exp 0", busy_o[9]);
    end
  endtask

  task automatic test_issue_done_collision();
    clear_inputs();
    mc_issue_i = 1; mc_rd_i = 5'd3;
    cycle();
    mc_done_i = 1; mc_done_rd_i = 5'd3; mc_done_data_i = 32'h3333;
    cycle();
    clear_inputs();
    checks++;
    if (busy_o[3] !== 1'b1) begin
      errors++;
      $display("FAIL issue_wins got %0b exp 1", busy_o[3]);
    end
    D_need_rd_i = 1; D_rd_i = 5'd3;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall got %0b exp 1", stall_o);
    end
    cycle();
    mc_done_i = 1; mc_done_rd_i = 5'd3; mc_done_data_i = 32'h4;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL waw_done_release got %0b exp 0", stall_o);
    end
    cycle();
  endtask

  task automatic test_flush();
    clear_inputs();
    mc_issue_i = 1; mc_rd_i = 5'd4;
    cycle();
    mc_issue_i = 1; mc_rd_i = 5'd0;
    cycle();
    checks++;
    if (busy_o !== 32'h10) begin
      errors++;
      $display("FAIL busy4_x0_ignored got %h exp 00000010", busy_o);
    end
    flush_i = 1; mc_done_i = 1; mc_done_rd_i = 5'd4; mc_issue_i = 1; mc_rd_i = 5'd6;
    cycle();
    clear_inputs();
    checks++;
    if (busy_o !== 32'h0) begin
      errors++;
      $display("FAIL flush_clear got %h exp 00000000", busy_o);
    end
    set_rs(0, 0, 32'hFFFF_FFFF);
    set_rs(1, 0, 32'h1);
    set_stg(0, 1, 0, 0, 32'h0);
    #1;
    checks++;
    if (fwd_of(0) !== 32'h0 || fwd_of(1) !== 32'h0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_never_stalls got %h %h stall %0b exp 0 0 stall 0", fwd_of(0), fwd_of(1), stall_o);
    end
    cycle();
  endtask

  task automatic test_watchdog();
    apply_reset();
    mc_issue_i = 1; mc_rd_i = 5'd10;
    cycle();
    mc_issue_i = 0;
    set_rs(0, 10, 32'h0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      cycle();
      if (i == TIMEOUT - 1) begin
        checks++;
        if (wdog_o !== 1'b0) begin
          errors++;
          $display("FAIL wdog_early got %0b exp 0", wdog_o);
        end
      end
    end
    checks++;
    if (wdog_o !== 1'b1) begin
      errors++;
      $display("FAIL wdog_trip got %0b exp 1", wdog_o);
    end
    mc_done_i = 1; mc_done_rd_i = 5'd10; mc_issue_i = 1; mc_rd_i = 5'd11;
    cycle();
    clear_inputs();
    cycle();
    checks++;
    if (wdog_o !== 1'b1 || busy_o !== 32'h800) begin
      errors++;
      $display("FAIL wdog_sticky wdog %0b busy %h exp 1 00000800", wdog_o, busy_o);
    end
    set_rs(1, 11, 32'h0);
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 32'h0 || perf_stall_o !== '0 || wdog_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset busy=%h perf=%0d wdog=%0b stall=%0b exp all 0", busy_o, perf_stall_o, wdog_o, stall_o);
    end
    model_reset();
    clear_inputs();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cycle();
  endtask

  task automatic test_perf_saturate();
    apply_reset();
    mc_issue_i = 1; mc_rd_i = 5'd12;
    cycle();
    mc_issue_i = 0;
    set_rs(1, 12, 32'h0);
    for (int i = 0; i < PMAX + 5; i++) cycle();
    checks++;
    if (perf_stall_o !== CNT_W'(PMAX)) begin
      errors++;
      $display("FAIL perf_saturate got %0d exp %0d", perf_stall_o, PMAX);
    end
    apply_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      flush_i     = ($urandom_range(0, 19) == 0);
      D_need_rd_i = 1'($urandom_range(0, 1));
      D_rd_i      = 5'($urandom_range(0, 7));
      for (int r = 0; r < NUM_RD; r++) set_rs(r, $urandom_range(0, 7), $urandom);
      for (int k = 0; k < NUM_STG; k++)
        set_stg(k, $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom);
      mc_issue_i     = ($urandom_range(0, 3) == 0);
      mc_rd_i        = 5'($urandom_range(0, 7));
      mc_done_i      = ($urandom_range(0, 2) == 0);
      mc_done_rd_i   = 5'($urandom_range(0, 7));
      mc_done_data_i = $urandom;
      cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_mc();
    test_issue_done_collision();
    test_flush();
    test_watchdog();
    test_perf_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
